// File: rtl/fetch_align_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_align_queue
// Purpose  : Halfword queue between fetch and decode; stitches 32-bit
//            instructions across fetch blocks and emits up to LANES per cycle.
// Revision : 1.0
// ============================================================================
module fetch_align_queue #(
    parameter int PC_BITS     = 32,
    parameter int FETCH_WIDTH = 64,
    parameter int LANES       = 2,
    parameter int DEPTH_HW    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   fetch_valid,
    output logic                                   fetch_ready,
    input  logic [PC_BITS-1:0]                     fetch_pc,
    input  logic [FETCH_WIDTH-1:0]                 fetch_data,
    input  logic [$clog2(FETCH_WIDTH/16):0]        fetch_hw_count,
    input  logic                                   fetch_taken,
    input  logic [$clog2(FETCH_WIDTH/16)-1:0]      fetch_taken_hw,
    output logic [LANES-1:0]                       out_valid,
    input  logic                                   out_ready,
    output logic [LANES*PC_BITS-1:0]               out_pc,
    output logic [LANES*32-1:0]                    out_instr,
    output logic [LANES-1:0]                       out_taken,
    output logic [$clog2(DEPTH_HW):0]              occupancy,
    output logic                                   orphan_drop
);

    localparam int HW_PER = FETCH_WIDTH / 16;
    localparam int TIDX_W = $clog2(HW_PER);
    localparam int CNT_W  = TIDX_W + 1;
    localparam int PTR_W  = $clog2(DEPTH_HW);
    localparam int OCC_W  = PTR_W + 1;
    localparam logic [OCC_W-1:0] C_DEPTH  = OCC_W'(DEPTH_HW);
    localparam logic [OCC_W-1:0] C_HW_PER = OCC_W'(HW_PER);

    logic [15:0]         r_data [DEPTH_HW];
    logic [PC_BITS-1:0]  r_pc   [DEPTH_HW];
    logic                r_tk   [DEPTH_HW];
    logic [PTR_W-1:0]    r_rd;
    logic [PTR_W-1:0]    r_wr;
    logic [OCC_W-1:0]    r_occ;

    logic [CNT_W-1:0]    w_push_cnt;
    logic [CNT_W-1:0]    w_taken_lim;
    logic                w_push;
    logic                w_orphan;
    logic [LANES:0]      w_chain;
    logic [LANES-1:0]    w_cond;
    logic [OCC_W-1:0]    w_lanes;
    logic [OCC_W-1:0]    w_pop;
    logic [PTR_W-1:0]    w_rd1;
    logic [PC_BITS-1:0]  w_base_pc;

    assign w_taken_lim = {1'b0, fetch_taken_hw} + CNT_W'(1);
    assign w_push_cnt  = (fetch_taken && (w_taken_lim < fetch_hw_count)) ? w_taken_lim
                                                                           : fetch_hw_count;
    assign fetch_ready = ~flush & ((C_DEPTH - r_occ) >= C_HW_PER);
    assign w_push      = fetch_valid & fetch_ready;
    assign w_base_pc   = fetch_pc & ~PC_BITS'(1);
    assign occupancy   = r_occ;

    // A head halfword that cannot pair with its successor would block the queue forever.
    assign w_rd1       = r_rd + PTR_W'(1);
    assign w_orphan    = ~flush & (r_occ >= OCC_W'(2)) &
                         ((r_pc[w_rd1] != r_pc[r_rd] + PC_BITS'(2)) | r_tk[r_rd]);
    assign orphan_drop = w_orphan;

    assign w_chain[0] = ~flush & ~w_orphan;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [PTR_W-1:0] w_a;
            logic [PTR_W-1:0] w_b;
            assign w_a = r_rd + PTR_W'(2 * k);
            assign w_b = w_a + PTR_W'(1);
            assign w_cond[k] = (r_occ >= OCC_W'(2 * k + 2)) &
                               (r_pc[w_b] == r_pc[w_a] + PC_BITS'(2)) & ~r_tk[w_a];
            assign w_chain[k+1] = w_chain[k] & w_cond[k];
            assign out_valid[k] = w_chain[k+1];
            assign out_pc[k*PC_BITS +: PC_BITS] = r_pc[w_a];
            assign out_instr[k*32 +: 32]        = {r_data[w_b], r_data[w_a]};
            assign out_taken[k]                 = r_tk[w_b];
        end
    endgenerate

    always_comb begin
        w_lanes = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lanes = w_lanes + OCC_W'(out_valid[k]);
        end
        if (w_orphan) begin
            w_pop = OCC_W'(1);
        end else if (out_ready && (|out_valid)) begin
            w_pop = w_lanes << 1;
        end else begin
            w_pop = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_occ <= '0;
        end else begin
            r_rd  <= r_rd + w_pop[PTR_W-1:0];
            if (w_push) begin
                r_wr <= r_wr + PTR_W'(w_push_cnt);
            end
            r_occ <= r_occ + (w_push ? OCC_W'(w_push_cnt) : OCC_W'(0)) - w_pop;
        end
    end

    // Storage carries no reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < HW_PER; i++) begin
                if (CNT_W'(i) < w_push_cnt) begin
                    r_data[r_wr + PTR_W'(i)] <= fetch_data[16*i +: 16];
                    r_pc[r_wr + PTR_W'(i)]   <= w_base_pc + PC_BITS'(2 * i);
                    r_tk[r_wr + PTR_W'(i)]   <= fetch_taken & (TIDX_W'(i) == fetch_taken_hw);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_align_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_align_queue
// Purpose  : Randomised + directed bench with a halfword-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_fetch_align_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [63:0] fetch_data;
    logic [2:0]  fetch_hw_count;
    logic        fetch_taken;
    logic [1:0]  fetch_taken_hw;
    logic [1:0]  out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_instr;
    logic [1:0]  out_taken;
    logic [4:0]  occupancy;
    logic        orphan_drop;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [31:0] pc;
        logic        tk;
    } hw_t;
    hw_t mq[$];

    fetch_align_queue #(.PC_BITS(32), .FETCH_WIDTH(64), .LANES(2), .DEPTH_HW(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .fetch_data(fetch_data), .fetch_hw_count(fetch_hw_count),
        .fetch_taken(fetch_taken), .fetch_taken_hw(fetch_taken_hw),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_taken(out_taken), .occupancy(occupancy),
        .orphan_drop(orphan_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: outputs are a pure function of the halfword list; the
    // list then absorbs whatever the inputs held before the coming clock edge.
    always @(negedge clk) begin : monitor
        int    n;
        int    pcnt;
        logic  orph;
        logic  prev;
        logic [1:0] ev;
        if (rst) begin
            mq.delete();
        end else begin
            n = mq.size();
            check("occupancy", 64'(occupancy), 64'(n));
            check("fetch_ready", 64'(fetch_ready), 64'(!flush && (16 - n) >= 4));
            orph = 1'b0;
            if (!flush && n >= 2) begin
                if (mq[1].pc != mq[0].pc + 32'd2 || mq[0].tk) orph = 1'b1;
            end
            ev   = 2'b00;
            prev = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (!flush && !orph && prev && n >= 2*k + 2) begin
                    if (mq[2*k+1].pc == mq[2*k].pc + 32'd2 && !mq[2*k].tk) ev[k] = 1'b1;
                end
                prev = ev[k];
            end
            check("out_valid", 64'(out_valid), 64'(ev));
            check("orphan_drop", 64'(orphan_drop), 64'(orph));
            for (int k = 0; k < 2; k++) begin
                if (ev[k]) begin
                    check($sformatf("lane%0d_pc", k), 64'(out_pc[k*32 +: 32]), 64'(mq[2*k].pc));
                    check($sformatf("lane%0d_instr", k), 64'(out_instr[k*32 +: 32]),
                          64'({mq[2*k+1].d, mq[2*k].d}));
                    check($sformatf("lane%0d_taken", k), 64'(out_taken[k]), 64'(mq[2*k+1].tk));
                end
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (orph) begin
                    void'(mq.pop_front());
                end else if (out_ready && ev != 2'b00) begin
                    for (int j = 0; j < 2 * $countones(ev); j++) void'(mq.pop_front());
                end
                if (fetch_valid && (16 - n) >= 4) begin
                    pcnt = int'(fetch_hw_count);
                    if (fetch_taken && int'(fetch_taken_hw) + 1 < pcnt) pcnt = int'(fetch_taken_hw) + 1;
                    for (int i = 0; i < pcnt; i++) begin
                        mq.push_back('{d: fetch_data[16*i +: 16],
                                       pc: {fetch_pc[31:1], 1'b0} + 32'(2*i),
                                       tk: fetch_taken && (i == int'(fetch_taken_hw))});
                    end
                end
            end
        end
    end

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [63:0] data,
                         input logic [2:0] cnt, input logic tk, input logic [1:0] thw,
                         input logic ordy, input logic fl);
        fetch_valid    = fv;
        fetch_pc       = pc;
        fetch_data     = data;
        fetch_hw_count = cnt;
        fetch_taken    = tk;
        fetch_taken_hw = thw;
        out_ready      = ordy;
        flush          = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'h0, 64'h0, 3'd1, 1'b0, 2'd0, ordy, 1'b0);
    endtask

    initial begin : stim
        logic [31:0] next_pc;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        tk;
        logic [1:0]  thw;
        int          p;
        rst = 1'b1;
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
        idle(1'b0);

        // aligned block, then one pop cycle
        drive(1'b1, 32'h100, 64'h4444_3333_2222_1111, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        // misaligned stitch
        drive(1'b1, 32'h206, 64'h0000_0000_0000_AAAA, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b1, 32'h208, 64'h0000_DDDD_CCCC_BBBB, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        drive(1'b0, 32'h0, 64'h0, 3'd1, 1'b0, 2'd0, 1'b0, 1'b1);
        // taken truncation and crossing into target
        drive(1'b1, 32'h300, 64'h9999_8888_7777_6666, 3'd4, 1'b1, 2'd1, 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b1, 32'h500, 64'h0000_0000_5555_5050, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        // orphan
        drive(1'b1, 32'h402, 64'h0000_0000_0000_0402, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h600, 64'h0000_0000_6602_6600, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        // fill to capacity, refused fifth offer, single pop
        for (int i = 0; i < 5; i++)
            drive(1'b1, 32'h700 + 32'(8*i), {4{16'(16'h7000 + i)}}, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 3'd1, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(1'b0);
        drive(1'b1, 32'h720, 64'h1234_5678_9ABC_DEF0, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0);
        // flush with push and pop requested
        drive(1'b1, 32'h800, 64'h1111_2222_3333_4444, 3'd4, 1'b0, 2'd0, 1'b1, 1'b1);
        idle(1'b0);
        // reset mid-stream at occupancy 6
        drive(1'b1, 32'h900, 64'h1, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h908, 64'h2, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
        idle(1'b0);

        next_pc = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            pc  = ($urandom_range(0, 9) < 8) ? next_pc : 32'($urandom_range(0, 32'hFFF)) & ~32'h1;
            cnt = 3'($urandom_range(1, 4));
            tk  = ($urandom_range(0, 9) == 0);
            thw = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) != 0 && fetch_ready_next()) begin
                p = int'(cnt);
                if (tk && int'(thw) + 1 < p) p = int'(thw) + 1;
                next_pc = pc + 32'(2*p);
            end
            drive(($urandom_range(0, 2) != 0), pc, {$urandom, $urandom}, cnt, tk, thw,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
        end
        rst = 1'b0;
        idle(1'b0);
        idle(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Stimulus-side guess of continuity only; never used as an expected value.
    function automatic logic fetch_ready_next();
        return 1'b1;
    endfunction

endmodule
`default_nettype wire

// File: doc/fetch_align_queue.md
Name: fetch_align_queue

Overview:
- Parametrised successor to the two-cycle half-access fetch stage.
- Sits between the icache/predictor fetch front and decode.
- Buffers fetched 16-bit halfwords with their PCs in a circular queue and stitches 32-bit instructions across fetch-block boundaries of any alignment.
- Emits up to LANES instructions per cycle with PC and taken-branch tag; supports flush and halfword truncation after a predicted-taken branch.

Parameters:
- PC_BITS, 32, PC width.
- FETCH_WIDTH, 64, fetch block bits; multiple of 16, >=32.
- LANES, 2, output instruction lanes, 1..4.
- DEPTH_HW, 16, queue capacity in halfwords; power of 2, >= FETCH_WIDTH/16 + 2*LANES.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all queue contents.
- fetch_valid  in  1  fetch block offered.
- fetch_ready  out  1  block accepted when fetch_valid & fetch_ready.
- fetch_pc  in  PC_BITS  PC of halfword 0; bit0 ignored.
- fetch_data  in  FETCH_WIDTH  halfword i = bits [16i+15:16i].
- fetch_hw_count  in  $clog2(FETCH_WIDTH/16)+1  valid halfwords, 1..FETCH_WIDTH/16.
- fetch_taken  in  1  predicted-taken branch ends inside this block.
- fetch_taken_hw  in  $clog2(FETCH_WIDTH/16)  index of the taken branch's last halfword.
- out_valid  out  LANES  per-lane valid; thermometer (lane k valid implies lanes <k valid).
- out_ready  in  1  consumer takes all valid lanes.
- out_pc  out  LANES*PC_BITS  lane PCs.
- out_instr  out  LANES*32  lane instructions; low halfword = lower PC.
- out_taken  out  LANES  lane instruction is the predicted-taken branch.
- occupancy  out  $clog2(DEPTH_HW)+1  halfwords held.
- orphan_drop  out  1  pulse: head halfword discarded.

Behaviour:
- Reset (synchronous, priority over all): rd/wr pointers 0, occupancy 0, out_valid 0, orphan_drop 0, fetch_ready 1. Storage arrays need no reset.
- Entry contents: 16-bit data, PC, taken bit.
- Push count P:
  - fetch_taken=0: P = fetch_hw_count.
  - fetch_taken=1: P = min(fetch_hw_count, fetch_taken_hw+1).
  - Halfwords beyond P are dropped.
- Pushed entry i gets PC = {fetch_pc[PC_BITS-1:1],1'b0} + 2i and taken = fetch_taken & (i == fetch_taken_hw).
- fetch_ready = ~flush & (DEPTH_HW - occupancy >= FETCH_WIDTH/16). It uses registered occupancy; same-cycle pops do not free space for the push.
- Output view is combinational from registered queue state only; no path from out_ready or fetch_* to out_*. Push-to-output latency is 1 cycle.
- Lane k validity (entries head+2k, head+2k+1):
  - both entries present;
  - PC(head+2k+1) == PC(head+2k)+2;
  - entry head+2k taken bit = 0;
  - orphan condition below inactive;
  - lane k-1 valid.
- Lane k outputs: instr = {data(head+2k+1), data(head+2k)}; pc = PC(head+2k); taken = taken(head+2k+1).
- Crossing a taken branch is allowed: the lane after a taken instruction may hold target-PC halfwords.
- Orphan: occupancy>=2, PC(head+1) != PC(head)+2 (or head entry's taken bit set).
  - out_valid = 0, head advances by 1 that cycle, orphan_drop=1.
  - Independent of out_ready.
- Pop: out_ready & |out_valid removes 2*popcount(out_valid) halfwords. out_ready with no valid lane is a no-op.
- Simultaneous push and pop: both apply. Next occupancy = occupancy + P(accepted) - popped. Pointers wrap modulo DEPTH_HW.
- Flush: pointers and occupancy cleared at the clock edge. Same-cycle push and pop suppressed; out_valid forced 0 in the flush cycle; orphan_drop 0.
- Occupancy never exceeds DEPTH_HW. A push with fetch_ready=0 is ignored and no entry changes.

Test Plan:
- Reset, then push pc=0x100, data 0x4444_3333_2222_1111, count 4 -> next cycle out_valid=2'b11, pc0=0x100 instr0=0x2222_1111, pc1=0x104 instr1=0x4444_3333, occupancy 4; out_ready=1 -> occupancy 0.
- Misaligned stitch: push pc=0x206 count 1 data 0xAAAA -> out_valid 0, occupancy 1; push pc=0x208 count 4 data 0x..._DDDD_CCCC_BBBB -> lane0 pc=0x206 instr=0xBBBB_AAAA, lane1 pc=0x20A instr=0xDDDD_CCCC.
- Taken truncation: pc=0x300 count 4, fetch_taken=1, taken_hw=1 -> occupancy 2, lane0 pc=0x300 taken=1; next push pc=0x500 count 2 -> lane1 pc=0x500 taken=0.
- Orphan: push pc=0x402 count 1, then pc=0x600 count 2 -> one cycle orphan_drop=1 with out_valid=0, then lane0 pc=0x600.
- Full/backpressure: out_ready=0, DEPTH_HW=16, four 4-halfword pushes -> occupancy 16, fetch_ready=0; fifth offer ignored. One out_ready cycle pops 4 -> fetch_ready=1 next cycle. Pointers verified across wrap.
- Flush and reset mid-stream: flush with fetch_valid=1 and out_ready=1 -> occupancy 0, no push, out_valid=0 in that cycle and the next; rst asserted with occupancy 6 -> all outputs at reset values next cycle.
